// File: rtl/pipe_flopr.sv
// pipe_flopr: STAGES-deep valid/ready register pipeline with stall, flush and bubble collapse.
// Define PIPE_FLOPR_SKID_EN to add a one-entry output skid register.
module pipe_flopr #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    input  logic                        stall,
    input  logic                        flush,
    output logic [$clog2(STAGES+2)-1:0] occupancy
);

    localparam int OW = $clog2(STAGES+2);

    logic [STAGES-1:0] v_q, v_d, adv;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [OW-1:0]     occ_q, occ_d;
    logic              go, last_adv, nxt;
    logic              xfer_in, xfer_out;
`ifdef PIPE_FLOPR_SKID_EN
    logic              sv_q, sv_d;
    logic [WIDTH-1:0]  sd_q, sd_d;
`endif

    always_comb begin
        go = ~stall & ~flush;
`ifdef PIPE_FLOPR_SKID_EN
        last_adv  = v_q[STAGES-1] & go & (~sv_q | out_ready);
        out_valid = reset & go & (sv_q | v_q[STAGES-1]);
        out_data  = sv_q ? sd_q : d_q[STAGES-1];
`else
        last_adv  = v_q[STAGES-1] & go & out_ready;
        out_valid = reset & go & v_q[STAGES-1];
        out_data  = d_q[STAGES-1];
`endif
        adv = '0;
        adv[STAGES-1] = last_adv;
        nxt = last_adv;
        // Walk back from the output so each stage sees whether its successor frees up.
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = v_q[i] & go & (~v_q[i+1] | nxt);
            nxt    = adv[i];
        end
`ifdef PIPE_FLOPR_SKID_EN
        in_ready = reset & go & ~sv_q;
`else
        in_ready = reset & go & (~v_q[0] | adv[0]);
`endif
        xfer_in  = in_valid & in_ready;
        xfer_out = out_valid & out_ready;
    end

    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        occ_d = occ_q;
`ifdef PIPE_FLOPR_SKID_EN
        sv_d  = sv_q;
        sd_d  = sd_q;
`endif
        if (flush) begin
            v_d   = '0;
            occ_d = '0;
            for (int i = 0; i < STAGES; i++) d_d[i] = '0;
`ifdef PIPE_FLOPR_SKID_EN
            sv_d  = 1'b0;
            sd_d  = '0;
`endif
        end else if (go) begin
            for (int i = STAGES - 1; i >= 1; i--) begin
                if (adv[i-1]) begin
                    v_d[i] = 1'b1;
                    d_d[i] = d_q[i-1];
                end else if (adv[i]) begin
                    v_d[i] = 1'b0;
                    d_d[i] = '0;
                end
            end
            if (xfer_in) begin
                v_d[0] = 1'b1;
                d_d[0] = in_data;
            end else if (adv[0]) begin
                v_d[0] = 1'b0;
                d_d[0] = '0;
            end
`ifdef PIPE_FLOPR_SKID_EN
            // Skid drains first; the last stage refills it behind the departing word.
            if (sv_q & out_ready) begin
                sv_d = v_q[STAGES-1];
                sd_d = d_q[STAGES-1];
            end else if (~sv_q & last_adv & ~out_ready) begin
                sv_d = 1'b1;
                sd_d = d_q[STAGES-1];
            end
`endif
            occ_d = occ_q + OW'(xfer_in) - OW'(xfer_out);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            d_q   <= '{default: '0};
            occ_q <= '0;
`ifdef PIPE_FLOPR_SKID_EN
            sv_q  <= 1'b0;
            sd_q  <= '0;
`endif
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
`ifdef PIPE_FLOPR_SKID_EN
            sv_q  <= sv_d;
            sd_q  <= sd_d;
`endif
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_flopr.sv
// tb_pipe_flopr: random and directed stimulus for pipe_flopr, checked by
// a FIFO reference model and a scoreboard monitor.
module tb_pipe_flopr;

    localparam int W = 8;
    localparam int S = 2;
`ifdef PIPE_FLOPR_SKID_EN
    localparam int CAP = S + 1;
`else
    localparam int CAP = S;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [W-1:0] in_data;
    logic         out_valid, out_ready;
    logic [W-1:0] out_data;
    logic         stall, flush;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [W-1:0] exp_q [$];

    pipe_flopr #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: set inputs after the edge, return mid-cycle with outputs settled.
    task automatic drive(input logic v, input logic [W-1:0] d,
                         input logic ordy, input logic st, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back(in_data);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("occupancy", longint'(occupancy), model_cnt);
            if (stall || flush) begin
                chk("hold_in_ready", longint'(in_ready), 0);
                chk("hold_out_valid", longint'(out_valid), 0);
            end
            if (model_cnt == 0) chk("empty_out_valid", longint'(out_valid), 0);
            if (model_cnt == CAP && !out_ready)
                chk("full_in_ready", longint'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected got=%0h expected=none", out_data);
                end else begin
                    chk("out_data", longint'(out_data), longint'(exp_q.pop_front()));
                end
            end
            if (flush) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                model_cnt += int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 0; in_data = '0;
        out_ready = 0; stall = 0; flush = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_occupancy", longint'(occupancy), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Streaming: first word visible two cycles after acceptance.
        drive(1, 8'h11, 1, 0, 0);
        chk("stream_c0", longint'(out_valid), 0);
        drive(1, 8'h22, 1, 0, 0);
        chk("stream_c1", longint'(out_valid), 0);
        drive(1, 8'h33, 1, 0, 0);
        chk("stream_c2_v", longint'(out_valid), 1);
        chk("stream_c2_d", longint'(out_data), 8'h11);
        drive(0, 8'h00, 1, 0, 0);
        chk("stream_c3_d", longint'(out_data), 8'h22);
        drive(0, 8'h00, 1, 0, 0);
        chk("stream_c4_d", longint'(out_data), 8'h33);
        drive(0, 8'h00, 1, 0, 0);

        // Stall holds 0xA5 in stage 0 for three cycles.
        drive(1, 8'hA5, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1, 1, 0);
            chk("stall_occ", longint'(occupancy), 1);
        end
        drive(0, 8'h00, 1, 0, 0);
        chk("stall_rel_v0", longint'(out_valid), 0);
        drive(0, 8'h00, 1, 0, 0);
        chk("stall_rel_v1", longint'(out_valid), 1);
        chk("stall_rel_d", longint'(out_data), 8'hA5);
        drive(0, 8'h00, 1, 0, 0);

        // Backpressure fill, then drain in order.
        for (int i = 0; i < 10; i++) begin
            drive(1, W'(8'h40 + i), 0, 0, 0);
            if (!in_ready) break;
        end
        chk("bp_in_ready", longint'(in_ready), 0);
        chk("bp_occ", longint'(occupancy), CAP);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            drive(0, 8'h00, 1, 0, 0);
        chk("bp_drain", exp_q.size(), 0);

        // Full-rate streaming keeps occupancy constant with in_ready high.
        for (int i = 0; i < 8; i++) begin
            drive(1, W'($urandom), 1, 0, 0);
            if (i >= S) begin
                chk("tput_in_ready", longint'(in_ready), 1);
                chk("tput_occ", longint'(occupancy), S);
            end
        end

        // Fill, then flush together with stall.
        for (int i = 0; i < 10; i++) begin
            drive(1, W'($urandom), 0, 0, 0);
            if (!in_ready) break;
        end
        chk("fl_full", longint'(occupancy), CAP);
        drive(0, 8'h00, 0, 1, 1);
        drive(0, 8'h00, 0, 0, 0);
        chk("fl_occ", longint'(occupancy), 0);
        chk("fl_out_valid", longint'(out_valid), 0);
        chk("fl_out_data", longint'(out_data), 0);

        // Reset asserted mid-stream.
        drive(1, 8'h61, 0, 0, 0);
        drive(1, 8'h62, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("mid_occ", longint'(occupancy), 2);
        in_valid = 0;
        reset = 1'b0;
        #1;
        chk("mid_out_valid", longint'(out_valid), 0);
        chk("mid_out_data", longint'(out_data), 0);
        chk("mid_occ0", longint'(occupancy), 0);
        chk("mid_in_ready", longint'(in_ready), 0);
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1, 8'h5C, 1, 0, 0);
        for (int i = 0; i < 10 && !out_valid; i++)
            drive(0, 8'h00, 1, 0, 0);
        chk("post_rst_valid", longint'(out_valid), 1);
        chk("post_rst_data", longint'(out_data), 8'h5C);

        // Randomized traffic with occasional stall and flush.
        for (int i = 0; i < 400; i++)
            drive(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
                  ($urandom % 16) == 0, ($urandom % 40) == 0);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            drive(0, 8'h00, 1, 0, 0);
        chk("final_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
